base_input_deser_ctl: RTL and testbench

- Framing and flow controller for a serial input capture path.
- Accepts a 1-bit stream with valid/ready, aligns words on a start-of-frame marker and assembles w-bit words.
- Presents each word on a registered valid/ready output port.
- Sits between the pad-side serial input and downstream parallel consumers; supplies backpressure so no bit is lost while a completed word waits.

---
 rtl/base_input_pkg.sv | 22 ++
 rtl/base_input_shift.sv | 50 +++++
 rtl/base_input_deser_ctl.sv | 159 +++++++++++++++
 tb/tb_base_input_deser_ctl.sv | 271 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/base_input_pkg.sv
// Shared types and sizing helpers for the serial input framing controller.
// Macro BASE_INPUT_PARITY_EN appends one even-parity bit to every word.
package base_input_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      STALL = 2'd2
   } state_e;

`ifdef BASE_INPUT_PARITY_EN
   localparam int PAR_BITS = 1;
`else
   localparam int PAR_BITS = 0;
`endif

   // Wide enough to hold the accept position of the last bit of a word.
   function automatic int cnt_w(input int width);
      return $clog2(width + PAR_BITS + 1);
   endfunction

endpackage

// File: rtl/base_input_shift.sv
// Word-assembly shift register: each new bit enters index 0, older bits move toward width-1.
// clr together with en starts a fresh word holding only the incoming bit.
module base_input_shift
   import base_input_pkg::*;
#(
   parameter int width = 8
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             en,
   input  logic             clr,
   input  logic             d,
   output logic [0:width-1] q,
   output logic [0:width-1] q_shift
);

   logic [0:width-1] q_q;
   logic [0:width-1] q_d;
   logic [0:width-1] fresh;

   generate
      if (width == 1) begin : g_single
         assign q_shift = d;
      end else begin : g_multi
         assign q_shift = {d, q_q[0:width-2]};
      end
   endgenerate

   always_comb begin
      fresh    = '0;
      fresh[0] = d;
      q_d      = q_q;
      if (en) begin
         q_d = clr ? fresh : q_shift;
      end else if (clr) begin
         q_d = '0;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         q_q <= '0;
      end else begin
         q_q <= q_d;
      end
   end

   assign q = q_q;

endmodule

// File: rtl/base_input_deser_ctl.sv
// Serial-to-parallel framing controller: aligns on i_sof, assembles w-bit words, registered output.
// Optional macro BASE_INPUT_PARITY_EN adds a trailing even-parity bit per word reported on o_perr.
module base_input_deser_ctl
   import base_input_pkg::*;
#(
   parameter int w = 8
) (
   input  logic         clk,
   input  logic         reset_n,
   input  logic         i_v,
   output logic         i_r,
   input  logic         i_sof,
   input  logic         i_d,
   output logic         o_v,
   input  logic         o_r,
   output logic [0:w-1] o_d,
   output logic         o_err,
   output logic         o_perr
);

   localparam int            CW     = cnt_w(w);
   localparam int            NB     = w + PAR_BITS;
   localparam logic [CW-1:0] NB_C   = CW'(NB);
   localparam logic [CW-1:0] W_C    = CW'(w);
   localparam logic [CW-1:0] ONE_C  = CW'(1);
   localparam logic          PAR_EN = (PAR_BITS == 1);

   // Handshakes: a bit moves when i_v & i_r, a word moves when o_v & o_r; o_v/o_d hold until then.
   state_e          state_q, state_d;
   logic [CW-1:0]   cnt_q, cnt_d;
   logic [CW-1:0]   pos;
   logic            o_v_q, o_v_d;
   logic [0:w-1]    o_d_q, o_d_d;
   logic            err_q, err_d;
   logic            o_perr_q, o_perr_d;
   logic            par_q, par_d;
   logic            hold_perr_q, hold_perr_d;
   logic            acc;
   logic            sr_en;
   logic            sr_clr;
   logic            perr_calc;
   logic [0:w-1]    sr_q;
   logic [0:w-1]    sr_shift;
   logic [0:w-1]    word_done;

   assign i_r = (state_q != STALL);
   assign acc = i_v & i_r;

   // With parity the completing accept is the parity bit, so the data is already in sr_q.
   assign word_done = PAR_EN ? sr_q : sr_shift;
   assign perr_calc = PAR_EN & (par_q ^ i_d);

   base_input_shift #(
      .width (w)
   ) u_shift (
      .clk     (clk),
      .reset_n (reset_n),
      .en      (sr_en),
      .clr     (sr_clr),
      .d       (i_d),
      .q       (sr_q),
      .q_shift (sr_shift)
   );

   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      o_v_d       = o_v_q & ~o_r;
      o_d_d       = o_d_q;
      err_d       = 1'b0;
      o_perr_d    = o_perr_q;
      par_d       = par_q;
      hold_perr_d = hold_perr_q;
      sr_en       = 1'b0;
      sr_clr      = 1'b0;
      pos         = '0;

      case (state_q)
         STALL: begin
            if (o_r) begin
               o_v_d    = 1'b1;
               o_d_d    = sr_q;
               o_perr_d = hold_perr_q;
               cnt_d    = '0;
               state_d  = SHIFT;
            end
         end
         default: begin
            if (acc) begin
               // pos is the 1-based position of this bit in its word; 0 means the bit is dropped.
               if (i_sof) begin
                  pos   = ONE_C;
                  err_d = (state_q == SHIFT) && (cnt_q != '0);
               end else if (state_q == IDLE) begin
                  err_d = 1'b1;
               end else begin
                  pos = cnt_q + ONE_C;
               end

               if (pos != '0) begin
                  if (pos <= W_C) begin
                     sr_en  = 1'b1;
                     sr_clr = (pos == ONE_C);
                     par_d  = (pos == ONE_C) ? i_d : (par_q ^ i_d);
                  end
                  if (pos == NB_C) begin
                     cnt_d = '0;
                     if (!o_v_q || o_r) begin
                        o_v_d    = 1'b1;
                        o_d_d    = word_done;
                        o_perr_d = perr_calc;
                        state_d  = SHIFT;
                     end else begin
                        hold_perr_d = perr_calc;
                        state_d     = STALL;
                     end
                  end else begin
                     cnt_d   = pos;
                     state_d = SHIFT;
                  end
               end
            end
         end
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q     <= IDLE;
         cnt_q       <= '0;
         o_v_q       <= 1'b0;
         o_d_q       <= '0;
         err_q       <= 1'b0;
         o_perr_q    <= 1'b0;
         par_q       <= 1'b0;
         hold_perr_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         o_v_q       <= o_v_d;
         o_d_q       <= o_d_d;
         err_q       <= err_d;
         o_perr_q    <= o_perr_d;
         par_q       <= par_d;
         hold_perr_q <= hold_perr_d;
      end
   end

   assign o_v   = o_v_q;
   assign o_d   = o_d_q;
   assign o_err = err_q;

`ifdef BASE_INPUT_PARITY_EN
   assign o_perr = o_perr_q;
`else
   assign o_perr = 1'b0;
`endif

endmodule

// File: tb/tb_base_input_deser_ctl.sv
// Bench for base_input_deser_ctl (w = 4): directed frames plus random traffic against a
// queue-based framing model; word order is tracked with an expected-word queue.
module tb_base_input_deser_ctl;

   localparam int W = 4;
`ifdef BASE_INPUT_PARITY_EN
   localparam int NB  = W + 1;
   localparam bit PAR = 1'b1;
`else
   localparam int NB  = W;
   localparam bit PAR = 1'b0;
`endif

   logic         clk;
   logic         reset_n;
   logic         i_v;
   logic         i_r;
   logic         i_sof;
   logic         i_d;
   logic         o_v;
   logic         o_r;
   logic [0:W-1] o_d;
   logic         o_err;
   logic         o_perr;

   base_input_deser_ctl #(
      .w (W)
   ) dut (
      .clk     (clk),
      .reset_n (reset_n),
      .i_v     (i_v),
      .i_r     (i_r),
      .i_sof   (i_sof),
      .i_d     (i_d),
      .o_v     (o_v),
      .o_r     (o_r),
      .o_d     (o_d),
      .o_err   (o_err),
      .o_perr  (o_perr)
   );

   // clock / reset
   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_checks;
   int n_errors;

   // reference model state
   bit           m_idle;
   bit           m_stall;
   bit           m_ov;
   bit           m_err;
   bit           m_perr;
   logic [W-1:0] m_od;
   logic [W-1:0] m_held;
   bit           m_held_perr;
   bit           m_bits[$];
   logic [W-1:0] exp_q[$];

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_idle      = 1'b1;
      m_stall     = 1'b0;
      m_ov        = 1'b0;
      m_err       = 1'b0;
      m_perr      = 1'b0;
      m_od        = '0;
      m_held      = '0;
      m_held_perr = 1'b0;
      m_bits.delete();
      exp_q.delete();
   endtask

   // One clock of the framing rules; the first received bit is the least significant bit of o_d.
   task automatic model_step(input bit v, input bit sof, input bit d, input bit r);
      bit           nov;
      bit           err;
      bit           pe;
      logic [W-1:0] wd;
      err = 1'b0;
      if (m_stall) begin
         if (r) begin
            m_od    = m_held;
            m_perr  = m_held_perr;
            m_stall = 1'b0;
         end
         nov = 1'b1;
      end else begin
         nov = m_ov && !r;
         if (v) begin
            if (sof) begin
               if (m_bits.size() != 0) err = 1'b1;
               m_bits.delete();
               m_bits.push_back(d);
               m_idle = 1'b0;
            end else if (m_idle) begin
               err = 1'b1;
            end else begin
               m_bits.push_back(d);
            end
            if (m_bits.size() == NB) begin
               wd = '0;
               pe = 1'b0;
               for (int k = 0; k < NB; k++) begin
                  if (k < W) wd[k] = m_bits[k];
                  pe ^= m_bits[k];
               end
               if (!PAR) pe = 1'b0;
               exp_q.push_back(wd);
               m_bits.delete();
               if (!m_ov || r) begin
                  m_od   = wd;
                  m_perr = pe;
                  nov    = 1'b1;
               end else begin
                  m_held      = wd;
                  m_held_perr = pe;
                  m_stall     = 1'b1;
               end
            end
         end
      end
      m_ov  = nov;
      m_err = err;
   endtask

   // driver: apply inputs, compare current outputs, advance model and clock
   task automatic cycle(input bit v, input bit sof, input bit d, input bit r);
      logic [W-1:0] od_num;
      i_v    = v;
      i_sof  = sof;
      i_d    = d;
      o_r    = r;
      od_num = o_d;
      check_eq("o_v", o_v, m_ov);
      check_eq("o_d", od_num, m_od);
      check_eq("o_err", o_err, m_err);
      check_eq("i_r", i_r, !m_stall);
      check_eq("o_perr", o_perr, m_perr);
      if (o_v && r) begin
         if (exp_q.size() == 0) check_eq("sb_underflow", 32'(exp_q.size()), 32'd1);
         else check_eq("sb_word", od_num, exp_q.pop_front());
      end
      model_step(v, sof, d, r);
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      reset_n = 1'b0;
      i_v     = 1'b0;
      i_sof   = 1'b0;
      model_reset();
      @(posedge clk);
      #1;
      reset_n = 1'b1;
   endtask

   logic [W-1:0] od_now;

   initial begin
      n_checks = 0;
      n_errors = 0;
      reset_n  = 1'b0;
      i_v      = 1'b0;
      i_sof    = 1'b0;
      i_d      = 1'b0;
      o_r      = 1'b0;
      model_reset();
      repeat (2) @(posedge clk);
      #1;
      od_now = o_d;
      check_eq("rst_o_v", o_v, 0);
      check_eq("rst_o_d", od_now, 0);
      check_eq("rst_o_err", o_err, 0);
      check_eq("rst_o_perr", o_perr, 0);
      check_eq("rst_i_r", i_r, 1);
      reset_n = 1'b1;

`ifndef BASE_INPUT_PARITY_EN
      // first frame 1,0,1,1 with consumer ready
      cycle(1, 1, 1, 1);
      cycle(1, 0, 0, 1);
      cycle(1, 0, 1, 1);
      cycle(1, 0, 1, 1);
      od_now = o_d;
      check_eq("frame1_o_v", o_v, 1);
      check_eq("frame1_o_d", od_now, 4'b1101);
      check_eq("frame1_o_err", o_err, 0);
`else
      // parity: data 1,1,0,1 with good then bad parity bit
      cycle(1, 1, 1, 1);
      cycle(1, 0, 1, 1);
      cycle(1, 0, 0, 1);
      cycle(1, 0, 1, 1);
      cycle(1, 0, 1, 1);
      od_now = o_d;
      check_eq("par_good_o_perr", o_perr, 0);
      check_eq("par_good_o_d", od_now, 4'b1011);
      cycle(1, 0, 1, 1);
      cycle(1, 0, 1, 1);
      cycle(1, 0, 0, 1);
      cycle(1, 0, 1, 1);
      cycle(1, 0, 0, 1);
      od_now = o_d;
      check_eq("par_bad_o_perr", o_perr, 1);
      check_eq("par_bad_o_d", od_now, 4'b1011);
`endif
      repeat (2) cycle(0, 0, 0, 1);

      // bits without sof while idle, then a framed word
      do_reset();
      repeat (3) cycle(1, 0, 1, 1);
      cycle(1, 1, 0, 1);
      for (int k = 1; k < NB; k++) cycle(1, 0, k[0], 1);
      repeat (2) cycle(0, 0, 0, 1);

      // consumer stalled for 10 cycles with a continuous stream
      cycle(1, 1, 1, 0);
      for (int k = 0; k < 9; k++) cycle(1, 0, 1'($urandom_range(0, 1)), 0);
      repeat (4) cycle(0, 0, 0, 1);

      // sof on the third bit restarts the word
      cycle(1, 1, 0, 1);
      cycle(1, 0, 1, 1);
      cycle(1, 1, 1, 1);
      for (int k = 1; k < NB; k++) cycle(1, 0, 1'($urandom_range(0, 1)), 1);
      repeat (2) cycle(0, 0, 0, 1);

      // asynchronous reset while a word is held
      cycle(1, 1, 1, 0);
      for (int k = 1; k < 2 * NB + 1; k++) cycle(1, 0, 1'($urandom_range(0, 1)), 0);
      check_eq("stall_i_r", i_r, 0);
      #2;
      reset_n = 1'b0;
      #1;
      od_now = o_d;
      check_eq("arst_o_v", o_v, 0);
      check_eq("arst_o_d", od_now, 0);
      check_eq("arst_i_r", i_r, 1);
      check_eq("arst_o_err", o_err, 0);
      model_reset();
      @(posedge clk);
      #1;
      reset_n = 1'b1;
      repeat (2) cycle(1, 0, 1, 1);
      cycle(1, 1, 1, 1);
      for (int k = 1; k < NB; k++) cycle(1, 0, 0, 1);
      repeat (2) cycle(0, 0, 0, 1);

      // random traffic with occasional resets
      for (int n = 0; n < 2000; n++) begin
         if ($urandom_range(0, 299) == 0) do_reset();
         cycle($urandom_range(0, 7) != 0, $urandom_range(0, 9) == 0,
               1'($urandom_range(0, 1)), $urandom_range(0, 3) != 0);
      end
      repeat (4) cycle(0, 0, 0, 1);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
